execute_stage: RTL and testbench

Second CPU pipeline stage, directly downstream of the fetch/decode stage and upstream of MEM/WB.
- Consumes the registered decode outputs: opcode, imm, sr1/sr2, data1/data2, writeback and control bits.
- Performs ALU, immediate-merge and address computation, with operand forwarding.
- Holds the NVZ flag register that is fed back to fetch/decode.
- Registers results for MEM/WB. Supports an optional iterative multiply that stalls the pipeline.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/ex_multiplier.sv | 80 ++++++++
 rtl/execute_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, flag bit positions,
// EX control bundle and multiply FSM states.
package cpu_pkg;

   localparam logic [4:0] OP_ADD     = 5'b00000;
   localparam logic [4:0] OP_SUB     = 5'b00001;
   localparam logic [4:0] OP_AND     = 5'b00010;
   localparam logic [4:0] OP_OR      = 5'b00011;
   localparam logic [4:0] OP_XOR     = 5'b00100;
   localparam logic [4:0] OP_SLL     = 5'b00101;
   localparam logic [4:0] OP_SRL     = 5'b00110;
   localparam logic [4:0] OP_BRANCH  = 5'b00111;
   localparam logic [4:0] OP_IMML    = 5'b01000;
   localparam logic [4:0] OP_IMMH    = 5'b01001;
   localparam logic [4:0] OP_LOAD    = 5'b01010;
   localparam logic [4:0] OP_STORE   = 5'b01011;
   localparam logic [4:0] OP_DBLOAD  = 5'b01100;
   localparam logic [4:0] OP_DBSTORE = 5'b01101;
   localparam logic [4:0] OP_MUL     = 5'b01110;

   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   typedef struct packed {
      logic alu2reg;
      logic mem2reg;
      logic bus2reg;
      logic mem_rd;
      logic mem_wr;
      logic bus_wr;
   } ex_ctrl_t;

endpackage

// File: rtl/ex_multiplier.sv
// Iterative shift-add multiplier, one partial product per clock.
// start_i launches, busy_o covers every iteration, done_o marks the last.
module ex_multiplier
   import cpu_pkg::*;
#(
   parameter int DW         = 16,
   parameter int MUL_CYCLES = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hold_i,
   input  logic          start_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [DW-1:0] prod_o
);

   localparam int CW = $clog2(MUL_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

   mul_state_t    state_q, state_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [DW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last;

   // prod_o already includes the current iteration's addend
   assign prod_o = acc_q + (b_q[0] ? a_q : '0);
   assign busy_o = (state_q == BUSY);
   assign last   = busy_o && (cnt_q == LAST);
   assign done_o = last && !hold_i;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start_i) begin
               state_d = BUSY;
               a_d     = a_i;
               b_d     = b_i;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            acc_d = prod_o;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (last) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else if (!hold_i) begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/execute_stage.sv
// EX stage: forwarding, ALU, NVZ flags and EX/MEM register.
// Define EX_MUL_EN to build the stalling iterative multiplier.
module execute_stage
   import cpu_pkg::*;
#(
   parameter int DW         = 16,
   parameter int RW         = 4,
   parameter int MUL_CYCLES = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [4:0]    iOpcode,
   input  logic [DW-1:0] iImm,
   input  logic [RW-1:0] iSr1,
   input  logic [RW-1:0] iSr2,
   input  logic [DW-1:0] iData1,
   input  logic [DW-1:0] iData2,
   input  logic          iAlutoReg,
   input  logic          iMemtoReg,
   input  logic          iBustoReg,
   input  logic [RW-1:0] iWriteBackAddr,
   input  logic          iALUSrc,
   input  logic          iMemRead,
   input  logic          iMemWrite,
   input  logic          iBusWrite,
   input  logic          iHalt,
   input  logic          iWbEn,
   input  logic [RW-1:0] iWbAddr,
   input  logic [DW-1:0] iWbData,
   output logic [2:0]    oNVZ,
   output logic [DW-1:0] oResult,
   output logic [DW-1:0] oStoreData,
   output logic          oAlutoReg,
   output logic          oMemtoReg,
   output logic          oBustoReg,
   output logic [RW-1:0] oWriteBackAddr,
   output logic          oMemRead,
   output logic          oMemWrite,
   output logic          oBusWrite,
   output logic          oStall
);

   logic [DW-1:0] result_q, result_d;
   logic [DW-1:0] store_q, store_d;
   ex_ctrl_t      ctrl_q, ctrl_d;
   logic [RW-1:0] wa_q, wa_d;
   logic [2:0]    nvz_q, nvz_d;

   logic [DW-1:0] op_a, op_b, alu_res, alu_sd;
   logic          op_ok, flag_we, alu_v;

   logic          mul_start, mul_busy, mul_done;
   logic [DW-1:0] mul_prod;
   logic          mul_alu;
   logic [RW-1:0] mul_wa;

   // ALUSrc selection and the high immediate byte are resolved upstream
   logic unused_inputs;
   assign unused_inputs = iALUSrc ^ (^iImm[DW-1:8]);

   // EX/MEM result beats MEM/WB; r0 is never forwarded
   function automatic logic [DW-1:0] fwd(
      input logic [RW-1:0] src,
      input logic [DW-1:0] rf,
      input logic          ex_en,
      input logic [RW-1:0] ex_a,
      input logic [DW-1:0] ex_v,
      input logic          wb_en,
      input logic [RW-1:0] wb_a,
      input logic [DW-1:0] wb_v
   );
      if (src == '0)                  return rf;
      else if (ex_en && ex_a == src) return ex_v;
      else if (wb_en && wb_a == src) return wb_v;
      else                            return rf;
   endfunction

   assign op_a = fwd(iSr1, iData1, ctrl_q.alu2reg, wa_q, result_q,
                     iWbEn, iWbAddr, iWbData);
   assign op_b = fwd(iSr2, iData2, ctrl_q.alu2reg, wa_q, result_q,
                     iWbEn, iWbAddr, iWbData);

   always_comb begin
      alu_res = '0;
      alu_sd  = '0;
      alu_v   = 1'b0;
      op_ok   = 1'b1;
      flag_we = 1'b0;
      unique case (iOpcode)
         OP_ADD: begin
            alu_res = op_a + op_b;
            alu_v   = (op_a[DW-1] == op_b[DW-1]) &&
                      (alu_res[DW-1] != op_a[DW-1]);
            flag_we = 1'b1;
         end
         OP_SUB: begin
            alu_res = op_a - op_b;
            alu_v   = (op_a[DW-1] != op_b[DW-1]) &&
                      (alu_res[DW-1] != op_a[DW-1]);
            flag_we = 1'b1;
         end
         OP_AND: begin
            alu_res = op_a & op_b;
            flag_we = 1'b1;
         end
         OP_OR: begin
            alu_res = op_a | op_b;
            flag_we = 1'b1;
         end
         OP_XOR: begin
            alu_res = op_a ^ op_b;
            flag_we = 1'b1;
         end
         OP_SLL: begin
            alu_res = op_a << op_b[3:0];
            flag_we = 1'b1;
         end
         OP_SRL: begin
            alu_res = op_a >> op_b[3:0];
            flag_we = 1'b1;
         end
         OP_BRANCH: alu_res = '0;
         OP_IMML:   alu_res = {op_a[DW-1:8], iImm[7:0]};
         OP_IMMH:   alu_res = {iImm[7:0], op_a[DW-9:0]};
         OP_LOAD, OP_DBLOAD: alu_res = op_a;
         OP_STORE, OP_DBSTORE: begin
            alu_res = op_a;
            alu_sd  = op_b;
         end
         default: op_ok = 1'b0;
      endcase
   end

`ifdef EX_MUL_EN
   logic          mul_alu_q;
   logic [RW-1:0] mul_wa_q;

   assign mul_start = !iHalt && !mul_busy && (iOpcode == OP_MUL);
   assign mul_alu   = mul_alu_q;
   assign mul_wa    = mul_wa_q;
   assign oStall    = mul_busy;

   ex_multiplier #(
      .DW         (DW),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .hold_i  (iHalt),
      .start_i (mul_start),
      .a_i     (op_a),
      .b_i     (op_b),
      .busy_o  (mul_busy),
      .done_o  (mul_done),
      .prod_o  (mul_prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_alu_q <= 1'b0;
         mul_wa_q  <= '0;
      end else if (mul_start) begin
         mul_alu_q <= iAlutoReg;
         mul_wa_q  <= iWriteBackAddr;
      end
   end
`else
   assign mul_start = 1'b0;
   assign mul_busy  = 1'b0;
   assign mul_done  = 1'b0;
   assign mul_prod  = '0;
   assign mul_alu   = 1'b0;
   assign mul_wa    = '0;
   assign oStall    = 1'b0;
`endif

   always_comb begin
      result_d = result_q;
      store_d  = store_q;
      ctrl_d   = ctrl_q;
      wa_d     = wa_q;
      nvz_d    = nvz_q;
      if (!iHalt) begin
         if (mul_done) begin
            result_d       = mul_prod;
            store_d        = '0;
            ctrl_d         = '0;
            ctrl_d.alu2reg = mul_alu;
            wa_d           = mul_wa;
            nvz_d[FLAG_N]  = mul_prod[DW-1];
            nvz_d[FLAG_V]  = 1'b0;
            nvz_d[FLAG_Z]  = (mul_prod == '0);
         end else if (mul_busy || mul_start || !op_ok) begin
            result_d = '0;
            store_d  = '0;
            ctrl_d   = '0;
            wa_d     = '0;
         end else begin
            result_d = alu_res;
            store_d  = alu_sd;
            ctrl_d   = '{alu2reg: iAlutoReg, mem2reg: iMemtoReg,
                         bus2reg: iBustoReg, mem_rd: iMemRead,
                         mem_wr: iMemWrite, bus_wr: iBusWrite};
            wa_d     = iWriteBackAddr;
            if (flag_we) begin
               nvz_d[FLAG_N] = alu_res[DW-1];
               nvz_d[FLAG_V] = alu_v;
               nvz_d[FLAG_Z] = (alu_res == '0);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         store_q  <= '0;
         ctrl_q   <= '0;
         wa_q     <= '0;
         nvz_q    <= '0;
      end else begin
         result_q <= result_d;
         store_q  <= store_d;
         ctrl_q   <= ctrl_d;
         wa_q     <= wa_d;
         nvz_q    <= nvz_d;
      end
   end

   assign oNVZ           = nvz_q;
   assign oResult        = result_q;
   assign oStoreData     = store_q;
   assign oAlutoReg      = ctrl_q.alu2reg;
   assign oMemtoReg      = ctrl_q.mem2reg;
   assign oBustoReg      = ctrl_q.bus2reg;
   assign oWriteBackAddr = wa_q;
   assign oMemRead       = ctrl_q.mem_rd;
   assign oMemWrite      = ctrl_q.mem_wr;
   assign oBusWrite      = ctrl_q.bus_wr;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: vector table plus
// multiply, reset-mid-multiply and halt sequences.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  iOpcode;
   logic [15:0] iImm;
   logic [3:0]  iSr1, iSr2;
   logic [15:0] iData1, iData2;
   logic        iAlutoReg, iMemtoReg, iBustoReg;
   logic [3:0]  iWriteBackAddr;
   logic        iALUSrc, iMemRead, iMemWrite, iBusWrite;
   logic        iHalt;
   logic        iWbEn;
   logic [3:0]  iWbAddr;
   logic [15:0] iWbData;
   logic [2:0]  oNVZ;
   logic [15:0] oResult, oStoreData;
   logic        oAlutoReg, oMemtoReg, oBustoReg;
   logic [3:0]  oWriteBackAddr;
   logic        oMemRead, oMemWrite, oBusWrite;
   logic        oStall;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   execute_stage dut (
      .clk(clk), .rst_n(rst_n),
      .iOpcode(iOpcode), .iImm(iImm),
      .iSr1(iSr1), .iSr2(iSr2),
      .iData1(iData1), .iData2(iData2),
      .iAlutoReg(iAlutoReg), .iMemtoReg(iMemtoReg),
      .iBustoReg(iBustoReg), .iWriteBackAddr(iWriteBackAddr),
      .iALUSrc(iALUSrc), .iMemRead(iMemRead),
      .iMemWrite(iMemWrite), .iBusWrite(iBusWrite),
      .iHalt(iHalt), .iWbEn(iWbEn),
      .iWbAddr(iWbAddr), .iWbData(iWbData),
      .oNVZ(oNVZ), .oResult(oResult), .oStoreData(oStoreData),
      .oAlutoReg(oAlutoReg), .oMemtoReg(oMemtoReg),
      .oBustoReg(oBustoReg), .oWriteBackAddr(oWriteBackAddr),
      .oMemRead(oMemRead), .oMemWrite(oMemWrite),
      .oBusWrite(oBusWrite), .oStall(oStall)
   );

   typedef struct {
      logic [4:0]  op;
      logic [15:0] imm;
      logic [3:0]  s1, s2;
      logic [15:0] d1, d2;
      logic        alu, mr;
      logic [3:0]  wa;
      logic        wben;
      logic [3:0]  wba;
      logic [15:0] wbd;
      logic [15:0] eres, esd;
      logic [2:0]  envz;
      logic        ealu, emr;
      logic [3:0]  ewa;
   } vec_t;

   vec_t vq[$];

   function automatic void add(
      input logic [4:0] op, input logic [15:0] imm,
      input logic [3:0] s1, input logic [3:0] s2,
      input logic [15:0] d1, input logic [15:0] d2,
      input logic alu, input logic mr, input logic [3:0] wa,
      input logic wben, input logic [3:0] wba, input logic [15:0] wbd,
      input logic [15:0] eres, input logic [15:0] esd,
      input logic [2:0] envz, input logic ealu, input logic emr,
      input logic [3:0] ewa);
      vec_t v;
      v.op = op; v.imm = imm; v.s1 = s1; v.s2 = s2;
      v.d1 = d1; v.d2 = d2; v.alu = alu; v.mr = mr; v.wa = wa;
      v.wben = wben; v.wba = wba; v.wbd = wbd;
      v.eres = eres; v.esd = esd; v.envz = envz;
      v.ealu = ealu; v.emr = emr; v.ewa = ewa;
      vq.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] op, input logic [15:0] imm,
                        input logic [3:0] s1, input logic [3:0] s2,
                        input logic [15:0] d1, input logic [15:0] d2,
                        input logic alu, input logic mr,
                        input logic [3:0] wa);
      iOpcode = op; iImm = imm; iSr1 = s1; iSr2 = s2;
      iData1 = d1; iData2 = d2; iAlutoReg = alu;
      iMemRead = mr; iWriteBackAddr = wa;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [15:0] res,
                          input logic [2:0] nvz, input logic [3:0] wa);
      chk({tag, "_result"}, 32'(oResult), 32'(res));
      chk({tag, "_nvz"}, 32'(oNVZ), 32'(nvz));
      chk({tag, "_wa"}, 32'(oWriteBackAddr), 32'(wa));
   endtask

   // SUB r1=1-2, ADD r2=r1+4, SUB r3=r2-8, optional halt before op2
   task automatic run3(input int halt_cycles, input string tag);
      drive(5'h01, 16'h0, 4'd1, 4'd2, 16'h0001, 16'h0002, 1, 0, 4'd1);
      step();
      chk_out({tag, "_op1"}, 16'hFFFF, 3'b100, 4'd1);
      drive(5'h00, 16'h0, 4'd1, 4'd2, 16'h0000, 16'h0004, 1, 0, 4'd2);
      iHalt = (halt_cycles > 0);
      for (int h = 0; h < halt_cycles; h++) begin
         step();
         chk_out({tag, "_hold"}, 16'hFFFF, 3'b100, 4'd1);
      end
      iHalt = 1'b0;
      step();
      chk_out({tag, "_op2"}, 16'h0003, 3'b000, 4'd2);
      drive(5'h01, 16'h0, 4'd2, 4'd1, 16'h0000, 16'h0008, 1, 0, 4'd3);
      step();
      chk_out({tag, "_op3"}, 16'hFFFB, 3'b100, 4'd3);
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0;
      drive(5'h1F, 16'h0, 4'd0, 4'd0, 16'h0, 16'h0, 0, 0, 4'd0);
      iMemtoReg = 0; iBustoReg = 0; iALUSrc = 0;
      iMemWrite = 0; iBusWrite = 0; iHalt = 0;
      iWbEn = 0; iWbAddr = 0; iWbData = 0;

      //  op     imm      s1 s2 d1       d2       al mr wa wb wba wbd  | res   sd  nvz al mr wa
      add(5'h00, 16'h0,   1, 2, 16'h7FFF,16'h0001,1, 0, 5, 0, 0, 16'h0, 16'h8000,16'h0,3'b110,1,0,5);
      add(5'h01, 16'h0,   1, 2, 16'h1234,16'h1234,1, 0, 6, 0, 0, 16'h0, 16'h0000,16'h0,3'b001,1,0,6);
      add(5'h07, 16'h0,   0, 0, 16'h0,   16'h0,   0, 0, 0, 0, 0, 16'h0, 16'h0000,16'h0,3'b001,0,0,0);
      add(5'h00, 16'h0,   1, 2, 16'h0002,16'h0003,1, 0, 3, 0, 0, 16'h0, 16'h0005,16'h0,3'b000,1,0,3);
      add(5'h00, 16'h0,   3, 3, 16'h0,   16'h0,   1, 0, 4, 0, 0, 16'h0, 16'h000A,16'h0,3'b000,1,0,4);
      add(5'h00, 16'h0,   1, 2, 16'h0001,16'h0001,1, 0, 0, 0, 0, 16'h0, 16'h0002,16'h0,3'b000,1,0,0);
      add(5'h00, 16'h0,   0, 0, 16'h0,   16'h0,   1, 0, 7, 0, 0, 16'h0, 16'h0000,16'h0,3'b001,1,0,7);
      add(5'h09, 16'h00AB,4, 0, 16'h00CD,16'h0,   1, 0, 4, 0, 0, 16'h0, 16'hABCD,16'h0,3'b001,1,0,4);
      add(5'h04, 16'h0,   8, 9, 16'h0,   16'h00FF,1, 0, 2, 1, 8, 16'h0F0F,16'h0FF0,16'h0,3'b000,1,0,2);
      add(5'h03, 16'h0,   2, 1, 16'h0,   16'h0001,1, 0, 3, 1, 2, 16'hFFFF,16'h0FF1,16'h0,3'b000,1,0,3);
      add(5'h05, 16'h0,   1, 2, 16'h0001,16'h001F,1, 0, 5, 0, 0, 16'h0, 16'h8000,16'h0,3'b100,1,0,5);
      add(5'h06, 16'h0,   1, 2, 16'h8000,16'h0004,1, 0, 5, 0, 0, 16'h0, 16'h0800,16'h0,3'b000,1,0,5);
      add(5'h02, 16'h0,   1, 2, 16'hF0F0,16'h0F0F,1, 0, 5, 0, 0, 16'h0, 16'h0000,16'h0,3'b001,1,0,5);
      add(5'h01, 16'h0,   1, 2, 16'h8000,16'h0001,1, 0, 5, 0, 0, 16'h0, 16'h7FFF,16'h0,3'b010,1,0,5);
      add(5'h0A, 16'h0,   1, 0, 16'h1234,16'h0,   0, 1, 6, 0, 0, 16'h0, 16'h1234,16'h0,3'b010,0,1,6);
      add(5'h0B, 16'h0,   1, 2, 16'h0100,16'hBEEF,0, 0, 0, 0, 0, 16'h0, 16'h0100,16'hBEEF,3'b010,0,0,0);
      add(5'h1F, 16'h0,   1, 2, 16'h0001,16'h0001,1, 1, 3, 0, 0, 16'h0, 16'h0000,16'h0,3'b010,0,0,0);
      add(5'h08, 16'h0056,1, 0, 16'h1200,16'h0,   1, 0, 1, 0, 0, 16'h0, 16'h1256,16'h0,3'b010,1,0,1);
      add(5'h01, 16'h0,   2, 3, 16'h0003,16'h0005,1, 0, 5, 0, 0, 16'h0, 16'hFFFE,16'h0,3'b100,1,0,5);

      #12;
      chk_out("reset", 16'h0, 3'b000, 4'd0);
      chk("reset_alu", 32'(oAlutoReg), 32'd0);
      chk("reset_stall", 32'(oStall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vq[i]) begin
         drive(vq[i].op, vq[i].imm, vq[i].s1, vq[i].s2,
               vq[i].d1, vq[i].d2, vq[i].alu, vq[i].mr, vq[i].wa);
         iWbEn = vq[i].wben; iWbAddr = vq[i].wba; iWbData = vq[i].wbd;
         step();
         chk($sformatf("v%0d_result", i), 32'(oResult), 32'(vq[i].eres));
         chk($sformatf("v%0d_store", i), 32'(oStoreData), 32'(vq[i].esd));
         chk($sformatf("v%0d_nvz", i), 32'(oNVZ), 32'(vq[i].envz));
         chk($sformatf("v%0d_ctrl", i),
             32'({oAlutoReg, oMemRead, oWriteBackAddr}),
             32'({vq[i].ealu, vq[i].emr, vq[i].ewa}));
      end
      iWbEn = 0; iWbAddr = 0; iWbData = 0;

`ifdef EX_MUL_EN
      drive(5'h0E, 16'h0, 4'd1, 4'd2, 16'h0003, 16'h0005, 1, 0, 4'd9);
      step();
      drive(5'h00, 16'h0, 4'd9, 4'd0, 16'h0, 16'h0, 1, 0, 4'd10);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (!oStall) break;
         cnt++;
         chk("mul_bubble", 32'({oResult, oAlutoReg, oWriteBackAddr}), 32'd0);
         step();
      end
      chk("mul_stall_cycles", 32'(cnt), 32'd16);
      chk_out("mul_done", 16'h000F, 3'b000, 4'd9);
      chk("mul_done_alu", 32'(oAlutoReg), 32'd1);
      step();
      chk_out("mul_fwd", 16'h000F, 3'b000, 4'd10);

      drive(5'h0E, 16'h0, 4'd1, 4'd2, 16'h0003, 16'h0005, 1, 0, 4'd9);
      step();
      for (int i = 1; i < 8; i++) step();
      chk("mul2_stall_c8", 32'(oStall), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mul_rst_stall", 32'(oStall), 32'd0);
      chk_out("mul_rst", 16'h0, 3'b000, 4'd0);
      drive(5'h00, 16'h0, 4'd1, 4'd2, 16'h0002, 16'h0003, 1, 0, 4'd6);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk_out("post_rst", 16'h0005, 3'b000, 4'd6);
      chk("post_rst_stall", 32'(oStall), 32'd0);
`else
      drive(5'h0E, 16'h0, 4'd1, 4'd2, 16'h0003, 16'h0005, 1, 0, 4'd9);
      step();
      chk("mul_off_stall", 32'(oStall), 32'd0);
      chk_out("mul_off", 16'h0, 3'b100, 4'd0);
      chk("mul_off_alu", 32'(oAlutoReg), 32'd0);
`endif

      run3(0, "run");
      run3(3, "halt");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
